board_monitor: RTL
==================

Name: board_monitor

Overview:
Parametrised board housekeeping block for the FPGA top levels. It combines four functions:
- PLL-lock-qualified reset synchroniser.
- Heartbeat blinker.
- Scanner that continuously byte-sums a JTAG register bank and flags changes.
- Mode-selectable LED driver.

It sits beside the PLL and JTAG_REGS in each board top and generalises ad-hoc reset/blink/scan logic to any clock rate, bank depth and LED count.

Parameters:
C_F_CK, 48_000_000, CK_i frequency in Hz.
C_BLINK_HZ, 1, heartbeat frequency in Hz. Half-period = C_F_CK/(2*C_BLINK_HZ) cycles; must be ≥2.
C_RST_STAGES, 3, synchroniser depth; minimum 2.
C_REG_BYTES, 128, bytes in the scanned bank; minimum 2.
C_STRETCH, 4_800_000, cycles the change indicator stays lit after SUM_CHG.
C_LED_N, 3, number of LED outputs.

Ports:
CK_i  in  1  single clock; all logic on posedge.
XARST_i  in  1  asynchronous active-low reset.
LOCK_i  in  1  PLL lock; asynchronous, active-high.
XRST_o  out  1  synchronised reset for downstream logic: asserts asynchronously, deasserts synchronously.
SCAN_EN_i  in  1  enables the next scan pass.
REGss_i  in  8*C_REG_BYTES  register bank; byte k = REGss_i[8k+:8].
HEART_o  out  1  heartbeat square wave.
SUM_o  out  8  last completed byte-sum, mod 256.
SUM_VLD_o  out  1  one-cycle pulse when SUM_o updates.
SUM_CHG_o  out  1  one-cycle pulse when the new sum differs from the previous sum.
LED_MODEs_i  in  2*C_LED_N  per-LED mode: 0 = HEART, 1 = change stretch, 2 = XRST_o, 3 = off.
zLEDs_o  out  C_LED_N  LED drive, active-low.

Behaviour:
- Reset synchroniser:
  - Shift chain of C_RST_STAGES flops, cleared asynchronously when XARST_i=0 or LOCK_i=0.
  - Otherwise it shifts in 1 each cycle.
  - XRST_o = last stage, so it goes high C_RST_STAGES rising edges after both inputs are high.
- All remaining logic is async-reset by XARST_i and synchronously held at reset values while XRST_o=0.
- Reset values:
  - HEART_o=0, SUM_o=0, SUM_VLD_o=0, SUM_CHG_o=0.
  - Stretch counter = 0, so zLEDs_o=all 1 (dark) except LEDs in mode 2, which show XRST_o=0 as lit.
  - FSM in IDLE; first-pass flag set.
- Heartbeat:
  - Down-counter loaded with half-period−1.
  - On reaching 0, HEART_o toggles and the counter reloads.
  - First toggle occurs half-period cycles after XRST_o rises.
- Scanner FSM, states IDLE, SCAN, DONE:
  - IDLE: if SCAN_EN_i=1, go to SCAN with idx=0 and acc=0. Otherwise stay.
  - SCAN: acc += byte[idx] (8-bit wrap); idx++. When idx = C_REG_BYTES−1, go to DONE. The byte is sampled in the cycle idx points at, so REGss_i may change mid-pass.
  - DONE, one cycle:
    - SUM_o ← acc.
    - SUM_VLD_o pulses on the following cycle, aligned with the new SUM_o.
    - SUM_CHG_o pulses together with SUM_VLD_o when acc≠old SUM_o and the first-pass flag is clear.
    - The first-pass flag then clears.
    - Next state is SCAN if SCAN_EN_i=1, else IDLE.
  - Pass period with SCAN_EN_i held high: C_REG_BYTES+1 cycles. SUM_VLD_o is periodic.
  - Deasserting SCAN_EN_i mid-pass does not abort; the pass completes and the FSM parks in IDLE.
  - Index width = clog2(C_REG_BYTES).
- Change stretch:
  - SUM_CHG_o loads the counter with C_STRETCH−1.
  - Otherwise it decrements to 0.
  - Indicator = (counter≠0) OR SUM_CHG_o.
  - A new change during an active stretch restarts it.
- LED driver: zLEDs_o[i] = ~ selected source, registered for one cycle.
- Reset mid-operation:
  - LOCK_i drop clears XRST_o immediately.
  - The next cycle, FSM/counters return to reset values.
  - SUM_o clears and the first-pass flag sets, so no spurious SUM_CHG_o after relock.

Decomposition:
Shared package (existing MISC include area) holds:
- LED mode encodings (LM_HEART=0, LM_CHG=1, LM_RST=2, LM_OFF=3).
- Scanner state encodings.
- A clog2 constant function.

One sub-module: rst_sync (parametrised C_RST_STAGES, inputs XARST_i/LOCK_i, output XRST_o), reusable for other clock domains. Everything else is inline.

Test Plan:
1. Reset release: C_RST_STAGES=3. XARST_i=1, LOCK_i rises at t0 → XRST_o=1 exactly at the 3rd rising edge after t0. LOCK_i=0 mid-run → XRST_o=0 with no clock edge.
2. Heartbeat: C_F_CK=8, C_BLINK_HZ=1 → HEART_o toggles every 4 cycles, first toggle 4 cycles after XRST_o=1, period 8.
3. Scan sum: C_REG_BYTES=4, bytes {0xFF,0x02,0x10,0x01}, SCAN_EN_i=1 → SUM_o=0x12 (wrap) with SUM_VLD_o pulse every 5 cycles. SUM_CHG_o=0 on the first pass.
4. Change detect: after test 3, set byte2=0x11 → next pass SUM_o=0x13, SUM_CHG_o=1 for 1 cycle. Following pass unchanged → SUM_CHG_o=0.
5. Stretch and LED modes: C_STRETCH=10, LED_MODEs_i={LM_CHG,LM_HEART,LM_OFF} → zLEDs_o[2] low for 10 cycles (one-cycle register delay) after SUM_CHG_o; zLEDs_o[1]=~HEART_o delayed 1 cycle; zLEDs_o[0]=1. Second change at cycle 5 of the stretch → low for 10 more cycles from that point.
6. Enable/abort: drop SCAN_EN_i at idx=1 → pass completes, one SUM_VLD_o, FSM in IDLE with no further pulses. Reassert → scanning resumes from idx=0. Pull LOCK_i low mid-scan → SUM_o=0, no SUM_CHG_o on the first pass after relock.

Source files
------------

// File: rtl/board_monitor_pkg.sv
// +--------------------------------------------------------------------+
// | board_monitor_pkg : LED mode / scanner state encodings, clog2.     |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

package board_monitor_pkg;

  typedef enum logic [1:0] {
    LM_HEART = 2'd0,
    LM_CHG   = 2'd1,
    LM_RST   = 2'd2,
    LM_OFF   = 2'd3
  } led_mode_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_DONE = 2'd2
  } scan_state_e;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

endpackage

`default_nettype wire

// File: rtl/rst_sync.sv
// +--------------------------------------------------------------------+
// | rst_sync : lock-qualified reset, async assert / sync deassert.     |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

module rst_sync #(
  parameter int C_RST_STAGES = 3
) (
  input  logic CK_i,
  input  logic XARST_i,
  input  logic LOCK_i,
  output logic XRST_o
);

  logic                    arst_n;
  logic [C_RST_STAGES-1:0] sync_q;

  // Losing PLL lock is treated exactly like the board reset pin.
  assign arst_n = XARST_i & LOCK_i;

  always_ff @(posedge CK_i or negedge arst_n) begin
    if (!arst_n) sync_q <= '0;
    else         sync_q <= {sync_q[C_RST_STAGES-2:0], 1'b1};
  end

  assign XRST_o = sync_q[C_RST_STAGES-1];

endmodule

`default_nettype wire

// File: rtl/board_monitor.sv
// +--------------------------------------------------------------------+
// | board_monitor : reset sync, heartbeat, register-bank checksum      |
// | scanner with change stretch, and mode-selectable LED driver.       |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

module board_monitor
  import board_monitor_pkg::*;
#(
  parameter int C_F_CK       = 48_000_000,
  parameter int C_BLINK_HZ   = 1,
  parameter int C_RST_STAGES = 3,
  parameter int C_REG_BYTES  = 128,
  parameter int C_STRETCH    = 4_800_000,
  parameter int C_LED_N      = 3
) (
  input  logic                     CK_i,
  input  logic                     XARST_i,
  input  logic                     LOCK_i,
  output logic                     XRST_o,
  input  logic                     SCAN_EN_i,
  input  logic [8*C_REG_BYTES-1:0] REGss_i,
  output logic                     HEART_o,
  output logic [7:0]               SUM_o,
  output logic                     SUM_VLD_o,
  output logic                     SUM_CHG_o,
  input  logic [2*C_LED_N-1:0]     LED_MODEs_i,
  output logic [C_LED_N-1:0]       zLEDs_o
);

  localparam int HALF  = C_F_CK / (2 * C_BLINK_HZ);
  localparam int HB_W  = clog2(HALF + 1);
  localparam int ST_W  = clog2(C_STRETCH + 1);
  localparam int IDX_W = clog2(C_REG_BYTES);
  localparam logic [HB_W-1:0]  HB_RELOAD = HB_W'(HALF - 1);
  localparam logic [ST_W-1:0]  ST_RELOAD = ST_W'(C_STRETCH - 1);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(C_REG_BYTES - 1);

  scan_state_e      state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [7:0]       acc_q, acc_d;
  logic [7:0]       sum_q, sum_d;
  logic             vld_q, vld_d;
  logic             chg_q, chg_d;
  logic             first_q, first_d;
  logic [HB_W-1:0]  hb_cnt_q, hb_cnt_d;
  logic             heart_q, heart_d;
  logic [ST_W-1:0]  st_cnt_q, st_cnt_d;
  logic [C_LED_N-1:0] led_q;
  logic [C_LED_N-1:0] w_led_src;
  logic             w_chg_ind;
  logic [7:0]       w_bytes [C_REG_BYTES];

  rst_sync #(
    .C_RST_STAGES (C_RST_STAGES)
  ) u_rst_sync (
    .CK_i    (CK_i),
    .XARST_i (XARST_i),
    .LOCK_i  (LOCK_i),
    .XRST_o  (XRST_o)
  );

  for (genvar k = 0; k < C_REG_BYTES; k++) begin : g_bytes
    assign w_bytes[k] = REGss_i[8*k +: 8];
  end

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    acc_d    = acc_q;
    sum_d    = sum_q;
    vld_d    = 1'b0;
    chg_d    = 1'b0;
    first_d  = first_q;
    hb_cnt_d = hb_cnt_q - 1'b1;
    heart_d  = heart_q;
    st_cnt_d = st_cnt_q;

    if (hb_cnt_q == '0) begin
      hb_cnt_d = HB_RELOAD;
      heart_d  = ~heart_q;
    end

    case (state_q)
      ST_IDLE: begin
        if (SCAN_EN_i) begin
          state_d = ST_SCAN;
          idx_d   = '0;
          acc_d   = '0;
        end
      end
      ST_SCAN: begin
        acc_d = acc_q + w_bytes[idx_q];
        idx_d = idx_q + 1'b1;
        if (idx_q == IDX_LAST) state_d = ST_DONE;
      end
      ST_DONE: begin
        sum_d   = acc_q;
        vld_d   = 1'b1;
        chg_d   = (acc_q != sum_q) && !first_q;
        first_d = 1'b0;
        idx_d   = '0;
        acc_d   = '0;
        state_d = SCAN_EN_i ? ST_SCAN : ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    if (chg_q)                st_cnt_d = ST_RELOAD;
    else if (st_cnt_q != '0)  st_cnt_d = st_cnt_q - 1'b1;

    // Held synchronously while the synchronised reset is low.
    if (!XRST_o) begin
      state_d  = ST_IDLE;
      idx_d    = '0;
      acc_d    = '0;
      sum_d    = '0;
      first_d  = 1'b1;
      hb_cnt_d = HB_RELOAD;
      heart_d  = 1'b0;
      st_cnt_d = '0;
    end
  end

  always_ff @(posedge CK_i or negedge XARST_i) begin
    if (!XARST_i) begin
      state_q  <= ST_IDLE;
      idx_q    <= '0;
      acc_q    <= '0;
      sum_q    <= '0;
      vld_q    <= 1'b0;
      chg_q    <= 1'b0;
      first_q  <= 1'b1;
      hb_cnt_q <= HB_RELOAD;
      heart_q  <= 1'b0;
      st_cnt_q <= '0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      acc_q    <= acc_d;
      sum_q    <= sum_d;
      vld_q    <= vld_d;
      chg_q    <= chg_d;
      first_q  <= first_d;
      hb_cnt_q <= hb_cnt_d;
      heart_q  <= heart_d;
      st_cnt_q <= st_cnt_d;
    end
  end

  assign w_chg_ind = (st_cnt_q != '0) | chg_q;

  // Mode 2 lights while reset is asserted, hence the inverted XRST_o source.
  always_comb begin
    w_led_src = '0;
    for (int i = 0; i < C_LED_N; i++) begin
      case (LED_MODEs_i[2*i +: 2])
        LM_HEART: w_led_src[i] = heart_q;
        LM_CHG:   w_led_src[i] = w_chg_ind;
        LM_RST:   w_led_src[i] = ~XRST_o;
        LM_OFF:   w_led_src[i] = 1'b0;
      endcase
    end
  end

  // Unreset on purpose: every source already sits at its reset value, so
  // one edge under reset settles the LEDs, including mode-dependent ones.
  always_ff @(posedge CK_i) begin
    led_q <= ~w_led_src;
  end

  assign HEART_o   = heart_q;
  assign SUM_o     = sum_q;
  assign SUM_VLD_o = vld_q;
  assign SUM_CHG_o = chg_q;
  assign zLEDs_o   = led_q;

endmodule

`default_nettype wire
